// File: rtl/guess_history_reader.sv
// ----------------------------------------------------------------------------
// guess_history_reader
//
// Walks the guess-history store and turns every stored row into a 19-byte
// ASCII line for the text sink:
//   "<p1 digits> <ball>B<strike>S|<p2 digits> <ball>B<strike>S\r\n"
// Rows are emitted newest first (row 0 .. NUM_ROWS-1).
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-low reset
//   start          one-cycle request to dump the history (ignored while busy)
//   output_number  nibble returned by the store for ascii_char (combinational)
//   ascii_char     lookup code driven to the store
//   tx_data        ASCII byte to the sink
//   tx_valid       tx_data is valid
//   tx_ready       sink accepts tx_data when tx_valid && tx_ready at clk
//   busy           dump in progress
//   done           one-cycle pulse after the last byte is accepted
// ----------------------------------------------------------------------------
module guess_history_reader #(
  parameter int         NUM_ROWS   = 4,
  parameter logic [7:0] ROW_BASE   = 8'h20,
  parameter logic [7:0] ROW_STRIDE = 8'h20,
  parameter logic [7:0] P2_OFFSET  = 8'h17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] output_number,
  output logic [7:0] ascii_char,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LOAD,
    SEND,
    DONE
  } state_t;

  localparam logic [4:0] LAST_STEP = 5'd18;
  localparam logic [2:0] LAST_ROW  = 3'(NUM_ROWS - 1);

  state_t     state;
  logic [2:0] row;
  logic [4:0] step;

  // Per-step decode: either a store lookup at (row base + offset) or a
  // constant byte.
  logic       lookup_step;
  logic [7:0] code_offset;
  logic [7:0] literal_byte;
  logic [7:0] row_base;
  logic [7:0] nibble_ascii;

  assign row_base     = ROW_BASE + (8'(row) * ROW_STRIDE);
  assign nibble_ascii = (output_number < 4'd10) ? (8'h30 + {4'h0, output_number}) : 8'h3F;

  always_comb begin
    lookup_step  = 1'b0;
    code_offset  = 8'h00;
    literal_byte = 8'h0A;
    case (step)
      5'd0:  begin lookup_step = 1'b1; code_offset = 8'd0; end
      5'd1:  begin lookup_step = 1'b1; code_offset = 8'd1; end
      5'd2:  begin lookup_step = 1'b1; code_offset = 8'd2; end
      5'd3:  literal_byte = 8'h20;
      5'd4:  begin lookup_step = 1'b1; code_offset = 8'd4; end
      5'd5:  literal_byte = 8'h42;
      5'd6:  begin lookup_step = 1'b1; code_offset = 8'd6; end
      5'd7:  literal_byte = 8'h53;
      5'd8:  literal_byte = 8'h7C;
      5'd9:  begin lookup_step = 1'b1; code_offset = P2_OFFSET; end
      5'd10: begin lookup_step = 1'b1; code_offset = P2_OFFSET + 8'd1; end
      5'd11: begin lookup_step = 1'b1; code_offset = P2_OFFSET + 8'd2; end
      5'd12: literal_byte = 8'h20;
      5'd13: begin lookup_step = 1'b1; code_offset = P2_OFFSET + 8'd4; end
      5'd14: literal_byte = 8'h42;
      5'd15: begin lookup_step = 1'b1; code_offset = P2_OFFSET + 8'd6; end
      5'd16: literal_byte = 8'h53;
      5'd17: literal_byte = 8'h0D;
      default: literal_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      row        <= 3'd0;
      step       <= 5'd0;
      ascii_char <= 8'h00;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            row   <= 3'd0;
            step  <= 5'd0;
            state <= ADDR;
          end
        end

        ADDR: begin
          if (lookup_step) begin
            ascii_char <= row_base + code_offset;
            state      <= LOAD;
          end else begin
            // Constant bytes need no store access, so they are loaded here
            // and cost one cycle less than lookups. ascii_char keeps its
            // previous lookup value.
            tx_data  <= literal_byte;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end

        LOAD: begin
          // output_number now reflects the ascii_char registered in ADDR.
          tx_data  <= lookup_step ? nibble_ascii : literal_byte;
          tx_valid <= 1'b1;
          state    <= SEND;
        end

        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (step == LAST_STEP) begin
              step <= 5'd0;
              if (row == LAST_ROW) begin
                state      <= DONE;
                done       <= 1'b1;
                busy       <= 1'b0;
                ascii_char <= 8'h00;
              end else begin
                row   <= row + 3'd1;
                state <= ADDR;
              end
            end else begin
              step  <= step + 5'd1;
              state <= ADDR;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_history_reader.sv
// ----------------------------------------------------------------------------
// Bench for guess_history_reader: a behavioural store model, a monitor that
// collects accepted bytes and lookup codes, and a reference model that builds
// the expected text lines directly from the row/field layout.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_guess_history_reader;

  localparam int NUM_ROWS   = 4;
  localparam int ROW_BASE   = 'h20;
  localparam int ROW_STRIDE = 'h20;
  localparam int P2_OFFSET  = 'h17;
  localparam int FRAME_LEN  = 19 * NUM_ROWS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       tx_ready = 1'b0;
  logic [3:0] output_number;
  logic [7:0] ascii_char;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       done;

  logic [3:0] store [256];
  assign output_number = store[ascii_char];

  guess_history_reader #(
    .NUM_ROWS  (NUM_ROWS),
    .ROW_BASE  (8'(ROW_BASE)),
    .ROW_STRIDE(8'(ROW_STRIDE)),
    .P2_OFFSET (8'(P2_OFFSET))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .output_number(output_number),
    .ascii_char   (ascii_char),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rx_q[$];
  logic [7:0] code_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_code_q[$];
  logic [7:0] ref_q[$];

  int         done_cnt = 0;
  int         busy_cnt = 0;
  int         ready_mode = 0;
  int         stall_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] last_code = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, between active edges.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
      last_code  = 8'h00;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (ready_mode == 2 && tx_valid && !tx_ready)
        check("stall_byte3", 32'(tx_data), 32'h20);
      if (tx_valid && tx_ready)
        rx_q.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (ascii_char != last_code) begin
        code_q.push_back(ascii_char);
        last_code = ascii_char;
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  // Sink readiness: 0 = always ready, 1 = random, 2 = 5-cycle stall on byte 3.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (rx_q.size() == 3 && tx_valid && stall_cnt < 5) begin
          tx_ready = 1'b0;
          stall_cnt++;
        end else begin
          tx_ready = 1'b1;
        end
      end
    endcase
  end

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'(48 + int'(n));
    return 8'h3F;
  endfunction

  // Reference model: each row is two player fields (digits, ball, strike)
  // separated by '|' and terminated by CR LF.
  function automatic void build_expected();
    int offs[5] = '{0, 1, 2, 4, 6};
    logic [7:0] f[5];
    logic [7:0] base;
    exp_q.delete();
    exp_code_q.delete();
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int p = 0; p < 2; p++) begin
        base = 8'(ROW_BASE + r * ROW_STRIDE + p * P2_OFFSET);
        for (int k = 0; k < 5; k++) begin
          f[k] = to_ascii(store[8'(base + offs[k])]);
          exp_code_q.push_back(8'(base + offs[k]));
        end
        exp_q.push_back(f[0]);
        exp_q.push_back(f[1]);
        exp_q.push_back(f[2]);
        exp_q.push_back(8'h20);
        exp_q.push_back(f[3]);
        exp_q.push_back(8'h42);
        exp_q.push_back(f[4]);
        exp_q.push_back(8'h53);
        exp_q.push_back((p == 0) ? 8'h7C : 8'h0D);
      end
      exp_q.push_back(8'h0A);
    end
    exp_code_q.push_back(8'h00);
  endfunction

  task automatic run_dump(input int mode, input bit poke);
    int cyc;
    rx_q.delete();
    code_q.delete();
    done_cnt   = 0;
    busy_cnt   = 0;
    stall_cnt  = 0;
    ready_mode = mode;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      @(posedge clk); #2;
      cyc++;
      start = poke && (cyc == 60);
    end
    start = 1'b0;
    check("dump_finished", 32'(done_cnt != 0), 32'd1);
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic compare_run(input int mode);
    build_expected();
    check("byte_count", 32'(rx_q.size()), 32'(FRAME_LEN));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check($sformatf("byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    check("code_count", 32'(code_q.size()), 32'(exp_code_q.size()));
    for (int i = 0; i < code_q.size() && i < exp_code_q.size(); i++)
      check($sformatf("code%0d", i), 32'(code_q[i]), 32'(exp_code_q[i]));
    check("done_pulses", 32'(done_cnt), 32'd1);
    if (mode == 0) check("busy_cycles", 32'(busy_cnt), 32'd192);
    $display("run mode=%0d bytes=%0d done=%0d busy_cycles=%0d", mode, rx_q.size(), done_cnt, busy_cnt);
  endtask

  task automatic fill_store();
    for (int i = 0; i < 256; i++) store[i] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    string row0;
    logic [7:0] row0_codes[10];
    int cyc;
    row0 = "123 1B2S|456 0B3S\r\n";
    row0_codes = '{8'h20, 8'h21, 8'h22, 8'h24, 8'h26, 8'h37, 8'h38, 8'h39, 8'h3B, 8'h3D};

    fill_store();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_code", 32'(ascii_char), 32'h0);
    check("rst_data", 32'(tx_data), 32'h0);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_valid", 32'(tx_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_code", 32'(ascii_char), 32'h0);
    end

    // Row 0 directed contents: P1 = 123 B1 S2, P2 = 456 B0 S3.
    for (int i = 0; i < 10; i++) store[row0_codes[i]] = 4'(0);
    store[8'h20] = 4'd1; store[8'h21] = 4'd2; store[8'h22] = 4'd3;
    store[8'h24] = 4'd1; store[8'h26] = 4'd2;
    store[8'h37] = 4'd4; store[8'h38] = 4'd5; store[8'h39] = 4'd6;
    store[8'h3B] = 4'd0; store[8'h3D] = 4'd3;
    run_dump(0, 1'b0);
    compare_run(0);
    for (int i = 0; i < 19 && i < rx_q.size(); i++)
      check($sformatf("row0_text%0d", i), 32'(rx_q[i]), 32'(8'(row0[i])));
    for (int i = 0; i < 10 && i < code_q.size(); i++)
      check($sformatf("row0_code%0d", i), 32'(code_q[i]), 32'(row0_codes[i]));
    ref_q = rx_q;

    // Backpressure on byte 3: stream must equal the unstalled one.
    run_dump(2, 1'b0);
    compare_run(2);
    check("stall_cycles", 32'(stall_cnt), 32'd5);
    check("stall_same_len", 32'(rx_q.size()), 32'(ref_q.size()));
    for (int i = 0; i < rx_q.size() && i < ref_q.size(); i++)
      check($sformatf("stall_same%0d", i), 32'(rx_q[i]), 32'(ref_q[i]));

    // Out-of-range nibble for row 1 tens digit.
    store[8'h41] = 4'hA;
    run_dump(0, 1'b0);
    compare_run(0);
    if (rx_q.size() > 20) check("row1_tens_q", 32'(rx_q[20]), 32'h3F);
    else check("row1_tens_present", 32'(rx_q.size()), 32'd21);

    // start while busy is ignored.
    run_dump(0, 1'b1);
    compare_run(0);

    // Reset in the middle of a dump.
    rx_q.delete();
    ready_mode = 0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    cyc = 0;
    while (rx_q.size() < 30 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_byte30", 32'(rx_q.size() >= 30), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("arst_valid", 32'(tx_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_code", 32'(ascii_char), 32'h0);
    check("arst_data", 32'(tx_data), 32'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("post_rst_valid", 32'(tx_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    run_dump(0, 1'b0);
    compare_run(0);

    // Randomised contents with random sink readiness.
    for (int t = 0; t < 4; t++) begin
      fill_store();
      run_dump(1, 1'b0);
      compare_run(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
